ctrl_mem_seq: RTL
=================

Name: ctrl_mem_seq

Overview:
Parametrised memory-access sequencer for the CGRA tile controller. It generalises the controller's single mem_read/mem_ack load path to NUM_CH requesting channels, with round-robin arbitration, one outstanding read, a MSG_DEPTH-entry message register file and an ack timeout. It sits between the controller's decode stage and the tile memory port. Its message file is the controller's messages/messReg source.

Parameters:
NUM_CH, 4, number of requesting channels (≥2)
AW, 32, memory address width
DW, 32, data/message width
MSG_DEPTH, 8, message register entries (power of 2)
SW, $clog2(MSG_DEPTH), slot index width (derived, not overridable)
TIMEOUT, 255, max cycles to wait for mem_ack (≥1, fits 8 bits)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_CH  per-channel load request
req_addr  in  NUM_CH*AW  per-channel address, channel i at [i*AW +: AW]
req_slot  in  NUM_CH*SW  destination message slot per channel
req_ready  out  NUM_CH  one-hot grant/accept pulse
mem_read  out  1  read strobe to memory
mem_address  out  AW  read address
mem_ack  in  1  memory data valid
mem_Message  in  DW  memory read data
messages  out  MSG_DEPTH*DW  message register file, entry j at [j*DW +: DW]
msg_valid  out  MSG_DEPTH  per-entry valid
msg_clr  in  MSG_DEPTH  per-entry consume/clear
done_valid  out  1  one-cycle completion pulse
done_ch  out  $clog2(NUM_CH)  channel of completed or timed-out request
err_timeout  out  1  one-cycle timeout pulse
busy  out  1  high in WAIT

Behaviour:
- Reset (rst_n low at posedge): state IDLE; rr_ptr=0; timeout counter=0; mem_read=0, mem_address=0, req_ready=0, messages all 0, msg_valid=0, done_valid=0, done_ch=0, err_timeout=0, busy=0. Reset mid-WAIT abandons the request; a late mem_ack after reset is ignored.
- FSM: IDLE, WAIT.
- IDLE arbitration:
  - Among asserted req_valid, grant the first channel at or after rr_ptr, searching cyclically.
  - req_ready[g] is combinational, high only in IDLE for the granted channel; the handshake completes that cycle.
  - On that edge: latch addr, slot and channel; rr_ptr <= (g+1) mod NUM_CH; counter <= 0; go WAIT.
  - No request: stay IDLE, rr_ptr unchanged.
- WAIT: mem_read=1 and mem_address=latched addr, both registered and stable for the whole state. Counter increments each cycle.
  - mem_ack high: messages[slot] <= mem_Message, msg_valid[slot] <= 1, done_valid pulse, done_ch <= latched channel, go IDLE. mem_read is low the next cycle.
  - Counter reaches TIMEOUT-1 with no ack: err_timeout and done_ch pulse, go IDLE. No write occurs and the slot is untouched. done_valid stays 0.
  - If mem_ack arrives on the timeout cycle, the ack wins.
- Latency: request accepted at edge N. mem_read is high from cycle N+1. Ack sampled at edge M puts data in messages and msg_valid from cycle M+1. Minimum accept-to-data is 2 cycles. Back-to-back accept is possible at edge M+1.
- mem_ack while in IDLE is ignored.
- msg_clr[j] clears msg_valid[j] only; data is retained. A clear and a write to the same entry on the same edge: the write wins (valid=1). A write to a slot whose valid is already 1 overwrites it silently; the requester owns slot discipline.
- No requests are lost: an ungranted req_valid is held by the requester until req_ready.
- Arithmetic: counter is 8-bit unsigned; rr_ptr wraps modulo NUM_CH (non-power-of-2 NUM_CH is supported).

Decomposition:
- Package ctrl_pkg:
  - state enum (IDLE, WAIT)
  - default widths (AW=32, DW=32)
  - TIMEOUT default constant
  - helper function for the cyclic first-one search
- Sub-module rr_arbiter (NUM_CH; inputs req, ptr; outputs one-hot grant and index).
- The message file stays inline.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'b1111 -> all outputs 0, no req_ready. Release, then ch0 is granted first (rr_ptr=0).
- Single load: ch2 addr=32'h0000_0040, slot=3; mem_ack after 3 WAIT cycles with mem_Message=32'hDEADBEEF -> mem_read high for 3 cycles at address 32'h40; messages[3]=32'hDEADBEEF; msg_valid=8'b0000_1000; done_valid pulse with done_ch=2.
- Round-robin: all channels continuously valid, ack on the 1st WAIT cycle -> grant order 0,1,2,3,0, one accept every 2 cycles.
- Timeout: TIMEOUT=4, ch1 request, never ack -> exactly 4 WAIT cycles, then err_timeout pulse with done_ch=1; msg_valid unchanged; next request is accepted normally.
- Clear/write collision: msg_clr[3] and an ack targeting slot 3 on the same edge -> msg_valid[3]=1 with the new data. msg_clr[3] alone next cycle -> valid 0, data retained.
- Reset mid-WAIT: rst_n low while WAIT, then mem_ack high after release -> IDLE, no message write, mem_read=0.

Source files
------------

// File: rtl/ctrl_mem_seq_pkg.sv
// Shared types, default widths and the cyclic first-one search used by the
// memory-access sequencer and its round-robin arbiter.
package ctrl_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int MAX_CH      = 32;

  // Returns {found, index} of the first set bit of req[n-1:0] at or after ptr,
  // wrapping cyclically; ptr must be < n.
  function automatic logic [5:0] rr_first(input logic [MAX_CH-1:0] req,
                                          input int n, input int ptr);
    logic       found;
    logic [4:0] idx;
    int         c;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      c = ptr + i;
      if (c >= n) c = c - n;
      if (!found && i < n && req[c[4:0]]) begin
        found = 1'b1;
        idx   = c[4:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/ctrl_mem_seq_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus index of the first
// requesting channel at or after ptr.
module rr_arbiter import ctrl_pkg::*; #(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     idx
);

  logic [5:0] res;

  always_comb begin
    res   = rr_first(MAX_CH'(req), NUM_CH, int'(ptr));
    idx   = res[CW-1:0];
    grant = res[5] ? (NUM_CH'(1) << res[4:0]) : '0;
  end

endmodule

// File: rtl/ctrl_mem_seq.sv
// Memory-access sequencer: arbitrates NUM_CH load channels, keeps one read in
// flight with an ack timeout, and writes results into a message register file.
module ctrl_mem_seq import ctrl_pkg::*; #(
  parameter  int NUM_CH    = 4,
  parameter  int AW        = DEF_AW,
  parameter  int DW        = DEF_DW,
  parameter  int MSG_DEPTH = 8,
  parameter  int TIMEOUT   = DEF_TIMEOUT,
  localparam int SW        = $clog2(MSG_DEPTH),
  localparam int CW        = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*AW-1:0]    req_addr,
  input  logic [NUM_CH*SW-1:0]    req_slot,
  output logic [NUM_CH-1:0]       req_ready,
  output logic                    mem_read,
  output logic [AW-1:0]           mem_address,
  input  logic                    mem_ack,
  input  logic [DW-1:0]           mem_Message,
  output logic [MSG_DEPTH*DW-1:0] messages,
  output logic [MSG_DEPTH-1:0]    msg_valid,
  input  logic [MSG_DEPTH-1:0]    msg_clr,
  output logic                    done_valid,
  output logic [CW-1:0]           done_ch,
  output logic                    err_timeout,
  output logic                    busy
);

  state_t                        state_q, state_d;
  logic [CW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [AW-1:0]                 addr_q, addr_d;
  logic [SW-1:0]                 slot_q, slot_d;
  logic [CW-1:0]                 ch_q, ch_d;
  logic                          mem_read_q, mem_read_d;
  logic                          done_valid_q, done_valid_d;
  logic [CW-1:0]                 done_ch_q, done_ch_d;
  logic                          err_timeout_q, err_timeout_d;
  logic [MSG_DEPTH-1:0][DW-1:0]  messages_q, messages_d;
  logic [MSG_DEPTH-1:0]          msg_valid_q, msg_valid_d;

  logic [NUM_CH-1:0][AW-1:0]     addr_arr;
  logic [NUM_CH-1:0][SW-1:0]     slot_arr;
  logic [NUM_CH-1:0]             grant;
  logic [CW-1:0]                 gidx;

  assign addr_arr = req_addr;
  assign slot_arr = req_slot;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    slot_d        = slot_q;
    ch_d          = ch_q;
    mem_read_d    = mem_read_q;
    done_valid_d  = 1'b0;
    done_ch_d     = done_ch_q;
    err_timeout_d = 1'b0;
    messages_d    = messages_q;
    msg_valid_d   = msg_valid_q & ~msg_clr;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        // No handshake while reset is held, so nobody sees a phantom accept.
        if (rst_n && |grant) begin
          req_ready  = grant;
          addr_d     = addr_arr[gidx];
          slot_d     = slot_arr[gidx];
          ch_d       = gidx;
          rr_ptr_d   = (gidx == CW'(NUM_CH-1)) ? '0 : gidx + CW'(1);
          cnt_d      = '0;
          mem_read_d = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is checked first so it wins over a same-cycle timeout.
        if (mem_ack) begin
          messages_d[slot_q]  = mem_Message;
          msg_valid_d[slot_q] = 1'b1;
          done_valid_d        = 1'b1;
          done_ch_d           = ch_q;
          mem_read_d          = 1'b0;
          state_d             = IDLE;
        end else if (cnt_q == 8'(TIMEOUT-1)) begin
          err_timeout_d = 1'b1;
          done_ch_d     = ch_q;
          mem_read_d    = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      slot_q        <= '0;
      ch_q          <= '0;
      mem_read_q    <= 1'b0;
      done_valid_q  <= 1'b0;
      done_ch_q     <= '0;
      err_timeout_q <= 1'b0;
      messages_q    <= '0;
      msg_valid_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      slot_q        <= slot_d;
      ch_q          <= ch_d;
      mem_read_q    <= mem_read_d;
      done_valid_q  <= done_valid_d;
      done_ch_q     <= done_ch_d;
      err_timeout_q <= err_timeout_d;
      messages_q    <= messages_d;
      msg_valid_q   <= msg_valid_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = addr_q;
  assign messages    = messages_q;
  assign msg_valid   = msg_valid_q;
  assign done_valid  = done_valid_q;
  assign done_ch     = done_ch_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q == WAIT);

endmodule
